sti_rx: RTL and testbench

STI_RX -- requirements
Module: sti_rx

---
 rtl/sti_rx.sv | 167 ++++++++++++++++
 tb/tb_sti_rx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_rx.sv
// Serial-to-pixel receiver.
// Collects serial bits into bytes (MSB- or LSB-first per word) and writes
// them to consecutive addresses of a 256-byte pixel memory. When the frame's
// final word ends early, the remaining addresses are zero-filled. Once all
// 256 addresses are written, the block parks in DONE until reset.
module sti_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       si_data,
  input  logic       si_valid,
  input  logic       si_msb,
  input  logic       si_end,
  output logic       px_wr,
  output logic [7:0] px_addr,
  output logic [7:0] px_data,
  output logic       rx_err,
  output logic       rx_finish
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;

  // Bit position within the byte being assembled; wraps 7 -> 0 on completion.
  logic [2:0]  bit_cnt_q;
  // Byte assembly register.
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  // Next address to write. Bit 8 is set once address 255 has been written,
  // which stops the pointer from wrapping and marks the frame as full.
  logic [8:0]  wr_ptr_q;
  logic        ptr_full;

  // Control strobes decoded from the current state and inputs.
  logic        take_bit;     // shift si_data into the assembly register
  logic        byte_done;    // this bit completes a byte
  logic        partial_err;  // word ended mid-byte
  logic        fill_wr;      // zero-fill write this cycle

  assign ptr_full = wr_ptr_q[8];

  // The incoming bit enters at the low end (MSB-first, shift left) or at the
  // high end (LSB-first, shift right).
  assign shift_d = si_msb ? {shift_q[6:0], si_data}
                          : {si_data, shift_q[7:1]};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred when a state does not change.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (si_valid) begin
          state_d = RECV;
        end
      end
      RECV: begin
        // A full frame wins over everything else: remaining bits and a late
        // si_end are both irrelevant once address 255 is written.
        if (ptr_full) begin
          state_d = DONE;
        end else if (!si_valid) begin
          state_d = si_end ? FILL : IDLE;
        end
      end
      FILL: begin
        if (ptr_full) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and datapath-control decode.
  always_comb begin
    take_bit    = 1'b0;
    partial_err = 1'b0;
    fill_wr     = 1'b0;
    rx_finish   = 1'b0;
    case (state_q)
      IDLE: begin
        // The first valid bit of a word is captured on the IDLE cycle itself.
        take_bit = si_valid;
      end
      RECV: begin
        take_bit    = si_valid && !ptr_full;
        // In RECV a low si_valid is always the falling edge of the word.
        partial_err = !si_valid && !ptr_full && (bit_cnt_q != 3'd0);
      end
      FILL: begin
        fill_wr = !ptr_full;
      end
      DONE: begin
        rx_finish = 1'b1;
      end
      default: begin
        take_bit = 1'b0;
      end
    endcase
  end

  assign byte_done = take_bit && (bit_cnt_q == 3'd7);

  // Byte assembly, write pointer and registered pixel-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      wr_ptr_q  <= 9'd0;
      px_wr     <= 1'b0;
      px_addr   <= 8'h00;
      px_data   <= 8'h00;
      rx_err    <= 1'b0;
    end else begin
      px_wr  <= 1'b0;
      rx_err <= partial_err;

      if (take_bit) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end else if (partial_err) begin
        // Discard the partial byte so the next word starts on a clean boundary.
        shift_q   <= 8'h00;
        bit_cnt_q <= 3'd0;
      end

      // Completed bytes and zero-fill never coincide: they live in different
      // states. px_addr/px_data keep their last values between writes.
      if (byte_done) begin
        px_wr    <= 1'b1;
        px_data  <= shift_d;
        px_addr  <= wr_ptr_q[7:0];
        wr_ptr_q <= wr_ptr_q + 9'd1;
      end else if (fill_wr) begin
        px_wr    <= 1'b1;
        px_data  <= 8'h00;
        px_addr  <= wr_ptr_q[7:0];
        wr_ptr_q <= wr_ptr_q + 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_sti_rx.sv
// Testbench for sti_rx: scoreboard of expected pixel writes (address, data
// and the exact cycle each write must appear), with per-scenario tasks.
module tb_sti_rx;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       si_data  = 1'b0;
  logic       si_valid = 1'b0;
  logic       si_msb   = 1'b0;
  logic       si_end   = 1'b0;
  logic       px_wr;
  logic [7:0] px_addr;
  logic [7:0] px_data;
  logic       rx_err;
  logic       rx_finish;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int err_seen = 0;
  int exp_ptr  = 0;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;

  sti_rx dut (
    .clk       (clk),
    .reset     (reset),
    .si_data   (si_data),
    .si_valid  (si_valid),
    .si_msb    (si_msb),
    .si_end    (si_end),
    .px_wr     (px_wr),
    .px_addr   (px_addr),
    .px_data   (px_data),
    .rx_err    (rx_err),
    .rx_finish (rx_finish)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every px_wr must match the oldest expected write exactly,
  // including the cycle it appears on; an expected write that does not show
  // up by its cycle is reported as missed.
  always @(negedge clk) begin
    if (!reset) begin
      if (px_wr === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=%h at cyc %0d, expected no write",
                   px_addr, px_data, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (px_addr !== mon_e.addr || px_data !== mon_e.data || cyc !== mon_e.cyc) begin
            failures++;
            $display("FAIL write: got addr=%0d data=%h cyc=%0d, expected addr=%0d data=%h cyc=%0d",
                     px_addr, px_data, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        checks++;
        failures++;
        mon_e = sb.pop_front();
        $display("FAIL missed_write: got px_wr=%b at cyc %0d, expected addr=%0d data=%h",
                 px_wr, cyc, mon_e.addr, mon_e.data);
      end
      if (rx_err === 1'b1) err_seen++;
    end
  end

  // Drive n bits of byte b in the order selected by msb; a completed byte
  // is expected on the bus exactly one cycle after its 8th bit is sampled.
  task automatic send_bits(input logic msb, input logic [7:0] b, input int n, input logic e);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      si_valid = 1'b1;
      si_msb   = msb;
      si_end   = e;
      si_data  = msb ? b[7 - i] : b[i];
      if (i == 7 && exp_ptr < 256) begin
        w.addr = 8'(exp_ptr);
        w.data = b;
        w.cyc  = cyc + 1;
        sb.push_back(w);
        exp_ptr++;
      end
    end
  endtask

  // Drop si_valid for one cycle. With e=1 the remaining addresses are
  // expected as zero writes, the first two cycles after the falling edge.
  task automatic end_word(input logic e);
    wr_t w;
    int  k;
    @(posedge clk); #1;
    si_valid = 1'b0;
    si_data  = 1'b0;
    si_end   = e;
    k = 0;
    if (e) begin
      while (exp_ptr < 256) begin
        w.addr = 8'(exp_ptr);
        w.data = 8'h00;
        w.cyc  = cyc + 2 + k;
        sb.push_back(w);
        exp_ptr++;
        k++;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      si_valid = 1'b0;
      si_end   = 1'b0;
      si_data  = 1'b0;
    end
  endtask

  // Wait (bounded) until the scoreboard has been consumed by the monitor.
  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b1;
    while (sb.size() > 0) begin
      if (budget == 0) begin
        ok = 1'b0;
        sb.delete();
        break;
      end
      @(negedge clk); #1;
      budget--;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    si_valid = 1'b0;
    si_end   = 1'b0;
    si_data  = 1'b0;
    sb.delete();
    exp_ptr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++;
    if (px_wr !== 1'b0) begin failures++; $display("FAIL reset_px_wr: got %b, expected 0", px_wr); end
    checks++;
    if (px_addr !== 8'h00) begin failures++; $display("FAIL reset_px_addr: got %h, expected 00", px_addr); end
    checks++;
    if (px_data !== 8'h00) begin failures++; $display("FAIL reset_px_data: got %h, expected 00", px_data); end
    checks++;
    if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err: got %b, expected 0", rx_err); end
    checks++;
    if (rx_finish !== 1'b0) begin failures++; $display("FAIL reset_rx_finish: got %b, expected 0", rx_finish); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_msb_first();
    bit ok;
    send_bits(1'b1, 8'hA5, 8, 1'b0);
    send_bits(1'b1, 8'hC3, 8, 1'b0);
    end_word(1'b0);
    idle(3);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL msb_drain: got pending writes, expected none"); end
    checks++;
    if (px_wr !== 1'b0 || px_addr !== 8'd1 || px_data !== 8'hC3) begin
      failures++;
      $display("FAIL msb_hold: got wr=%b addr=%0d data=%h, expected wr=0 addr=1 data=c3",
               px_wr, px_addr, px_data);
    end
    checks++;
    if (rx_finish !== 1'b0) begin failures++; $display("FAIL msb_finish: got %b, expected 0", rx_finish); end
  endtask

  task automatic test_lsb_first();
    bit ok;
    send_bits(1'b0, 8'h01, 8, 1'b0);
    end_word(1'b0);
    idle(2);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL lsb_drain: got pending writes, expected none"); end
    checks++;
    if (px_addr !== 8'd2 || px_data !== 8'h01) begin
      failures++;
      $display("FAIL lsb_byte: got addr=%0d data=%h, expected addr=2 data=01", px_addr, px_data);
    end
    send_bits(1'b0, 8'hB4, 8, 1'b0);
    end_word(1'b0);
    idle(2);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL lsb_drain2: got pending writes, expected none"); end
  endtask

  task automatic test_partial();
    bit ok;
    int e0;
    e0 = err_seen;
    send_bits(1'b1, 8'h5A, 8, 1'b0);
    send_bits(1'b1, 8'h9F, 4, 1'b0);
    end_word(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (rx_err !== 1'b1) begin failures++; $display("FAIL partial_err_pulse: got %b, expected 1", rx_err); end
    @(negedge clk);
    checks++;
    if (rx_err !== 1'b0) begin failures++; $display("FAIL partial_err_width: got %b, expected 0", rx_err); end
    send_bits(1'b1, 8'h81, 8, 1'b0);
    end_word(1'b0);
    idle(3);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL partial_drain: got pending writes, expected none"); end
    checks++;
    if (err_seen - e0 != 1) begin
      failures++;
      $display("FAIL partial_err_count: got %0d pulses, expected 1", err_seen - e0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 6; i++) send_bits(1'b0, 8'($urandom_range(255)), 8, 1'b0);
    end_word(1'b0);
    idle(3);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_drain: got pending writes, expected none"); end
  endtask

  task automatic test_end_fill();
    bit ok;
    bit bad;
    do_reset();
    send_bits(1'b1, 8'h11, 8, 1'b0);
    send_bits(1'b1, 8'h22, 8, 1'b0);
    end_word(1'b0);
    send_bits(1'b1, 8'h33, 8, 1'b1);
    end_word(1'b1);
    wait_drain(600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL fill_drain: got pending writes, expected none"); end
    checks++;
    if (rx_finish !== 1'b0) begin failures++; $display("FAIL fill_finish_early: got %b, expected 0", rx_finish); end
    @(negedge clk);
    checks++;
    if (rx_finish !== 1'b1 || px_wr !== 1'b0) begin
      failures++;
      $display("FAIL fill_done: got finish=%b wr=%b, expected finish=1 wr=0", rx_finish, px_wr);
    end
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      si_valid = 1'($urandom_range(1));
      si_data  = 1'($urandom_range(1));
      si_end   = 1'($urandom_range(1));
      si_msb   = 1'($urandom_range(1));
      @(negedge clk);
      if (rx_finish !== 1'b1 || px_wr !== 1'b0) bad = 1'b1;
    end
    idle(1);
    checks++;
    if (bad) begin failures++; $display("FAIL done_hold: got change in DONE, expected finish=1 wr=0"); end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int i = 0; i < 260; i++) send_bits(1'b1, 8'($urandom_range(255)), 8, 1'b0);
    end_word(1'b0);
    idle(3);
    wait_drain(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ovf_drain: got pending writes, expected none"); end
    @(negedge clk);
    checks++;
    if (rx_finish !== 1'b1 || px_wr !== 1'b0 || px_addr !== 8'd255) begin
      failures++;
      $display("FAIL ovf_done: got finish=%b wr=%b addr=%0d, expected finish=1 wr=0 addr=255",
               rx_finish, px_wr, px_addr);
    end
  endtask

  task automatic test_full_then_end();
    bit ok;
    logic [7:0] last;
    do_reset();
    last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      last = 8'($urandom_range(255));
      send_bits(1'b0, last, 8, 1'b0);
    end
    end_word(1'b1);
    idle(5);
    wait_drain(10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_drain: got pending writes, expected none"); end
    checks++;
    if (rx_finish !== 1'b1 || px_addr !== 8'd255 || px_data !== last) begin
      failures++;
      $display("FAIL full_end: got finish=%b addr=%0d data=%h, expected finish=1 addr=255 data=%h",
               rx_finish, px_addr, px_data, last);
    end
  endtask

  task automatic test_reset_mid_fill();
    bit ok;
    bit found;
    do_reset();
    send_bits(1'b0, 8'hE7, 8, 1'b0);
    send_bits(1'b0, 8'h3D, 8, 1'b1);
    end_word(1'b1);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk); #1;
      if (px_wr === 1'b1 && px_addr === 8'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rst_fill_reach: got no write at addr 100, expected one"); end
    reset    = 1'b1;
    si_end   = 1'b0;
    si_valid = 1'b0;
    #1;
    checks++;
    if (px_wr !== 1'b0 || px_addr !== 8'h00 || px_data !== 8'h00 || rx_err !== 1'b0 || rx_finish !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill_outputs: got wr=%b addr=%h data=%h err=%b fin=%b, expected all 0",
               px_wr, px_addr, px_data, rx_err, rx_finish);
    end
    sb.delete();
    exp_ptr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(5);
    send_bits(1'b1, 8'h77, 8, 1'b0);
    end_word(1'b0);
    idle(3);
    wait_drain(20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_fill_drain: got pending writes, expected none"); end
    checks++;
    if (px_addr !== 8'd0 || px_data !== 8'h77 || rx_finish !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill_restart: got addr=%0d data=%h fin=%b, expected addr=0 data=77 fin=0",
               px_addr, px_data, rx_finish);
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_partial();
    test_back_to_back();
    test_end_fill();
    test_overflow();
    test_full_then_end();
    test_reset_mid_fill();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
